aes_cipher_uart_tx: RTL



---
 rtl/aes_cipher_uart_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/aes_cipher_uart_tx.sv
// UART 8N1 serializer for one AES-128 ciphertext block, MSB byte first, LSB of each byte first.
// Optional AES_TX_CRLF_EN appends 0x0D 0x0A after the 16 ciphertext bytes.
module aes_cipher_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_W       = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

`ifdef AES_TX_CRLF_EN
    localparam int unsigned HOLD_W = DATA_W + 16;
`else
    localparam int unsigned HOLD_W = DATA_W;
`endif
    localparam int unsigned NBYTES = HOLD_W / 8;
    localparam int unsigned BYTE_W = $clog2(NBYTES);
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [2:0]          bit_idx, bit_idx_nxt;
    logic [BYTE_W-1:0]   byte_idx, byte_idx_nxt;
    logic [HOLD_W-1:0]   hold, hold_nxt, hold_load;
    logic                tx_nxt, done_nxt;
    logic                bit_end;
    logic [7:0]          cur_byte;

`ifdef AES_TX_CRLF_EN
    assign hold_load = {din, 8'h0D, 8'h0A};
`else
    assign hold_load = din;
`endif

    assign cur_byte = hold[HOLD_W-1 -: 8];
    assign bit_end  = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // State and datapath registers; tx is driven from the next-state decode so it lands with the state
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            hold      <= '0;
            tx        <= 1'b1;
            done      <= 1'b0;
            din_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            byte_idx  <= byte_idx_nxt;
            hold      <= hold_nxt;
            tx        <= tx_nxt;
            done      <= done_nxt;
            din_ready <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        bit_idx_nxt  = bit_idx;
        byte_idx_nxt = byte_idx;
        hold_nxt     = hold;
        tx_nxt       = 1'b1;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    state_nxt    = START;
                    hold_nxt     = hold_load;
                    bit_cnt_nxt  = '0;
                    bit_idx_nxt  = '0;
                    byte_idx_nxt = '0;
                    tx_nxt       = 1'b0;
                end
            end
            START: begin
                tx_nxt      = 1'b0;
                bit_cnt_nxt = bit_cnt + CNT_W'(1);
                if (bit_end) begin
                    bit_cnt_nxt = '0;
                    state_nxt   = DATA;
                    tx_nxt      = cur_byte[0];
                end
            end
            DATA: begin
                tx_nxt      = cur_byte[bit_idx];
                bit_cnt_nxt = bit_cnt + CNT_W'(1);
                if (bit_end) begin
                    bit_cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        tx_nxt      = cur_byte[bit_idx_nxt];
                    end
                end
            end
            STOP: begin
                tx_nxt      = 1'b1;
                bit_cnt_nxt = bit_cnt + CNT_W'(1);
                if (bit_end) begin
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    if (byte_idx == BYTE_W'(NBYTES - 1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        // Next start bit follows immediately, no idle gap
                        state_nxt    = START;
                        tx_nxt       = 1'b0;
                        byte_idx_nxt = byte_idx + BYTE_W'(1);
                        hold_nxt     = {hold[HOLD_W-9:0], 8'h00};
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
